// File: rtl/ex_mem.sv
// ---------------------------------------------------------------------------
// ex_mem -- execute / memory-access pipeline register of the five-stage core.
//
// Captures the execute-stage result (destination, write enable, write data,
// HI/LO update) on each rising clock edge and presents it to the memory
// stage. It applies the pipeline stall/flush policy. It also carries the
// multi-cycle accumulate state (64-bit partial product and step count)
// across execute-stage stalls for two-cycle multiply-accumulate operations.
//
// Configuration macro: EX_MEM_HILO_EN
//   defined   : HI/LO capture and hilo_temp/cnt return paths are implemented.
//   undefined : mem_whilo, mem_hi, mem_lo, hilo_temp_o and cnt_o are tied to
//               zero and their inputs are ignored (cores without mul/div).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stall_ex, stall_mem stage hold requests from the stall controller
//   flush               discard register contents (exception / redirect)
//   ex_*                execute-stage result to be captured
//   hilo_temp_i, cnt_i  accumulate state produced by execute
//   mem_*               registered result presented to the memory stage
//   mem_valid           slot holds a real instruction (0 = bubble)
//   hilo_temp_o, cnt_o  accumulate state returned to execute
// ---------------------------------------------------------------------------
module ex_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_ex,
  input  logic                stall_mem,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_rw,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] hilo_temp_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic [ADDR_W-1:0]   mem_rw,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_valid,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [CNT_W-1:0]    cnt_o
);

  logic [ADDR_W-1:0] rw_r;
  logic              wreg_r;
  logic [DATA_W-1:0] wdata_r;
  logic              valid_r;

  // Register-file payload and slot valid. A stalled execute stage with a
  // free memory stage yields a bubble; a fully stalled pair holds. The
  // stall_ex=0/stall_mem=1 combination is illegal and is treated as a
  // normal capture.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rw_r    <= {ADDR_W{1'b0}};
      wreg_r  <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
    end else if (!stall_ex) begin
      rw_r    <= ex_rw;
      wreg_r  <= ex_wreg;
      wdata_r <= ex_wdata;
      valid_r <= 1'b1;
    end else if (!stall_mem) begin
      rw_r    <= {ADDR_W{1'b0}};
      wreg_r  <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
    end else begin
      rw_r    <= rw_r;
      wreg_r  <= wreg_r;
      wdata_r <= wdata_r;
      valid_r <= valid_r;
    end
  end

  assign mem_rw    = rw_r;
  assign mem_wreg  = wreg_r;
  assign mem_wdata = wdata_r;
  assign mem_valid = valid_r;

`ifdef EX_MEM_HILO_EN
  logic                whilo_r;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;
  logic [2*DATA_W-1:0] temp_r;
  logic [CNT_W-1:0]    cnt_r;

  // HI/LO payload follows the same capture/bubble/hold policy as the
  // register payload so a bubble never updates HI/LO.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      whilo_r <= 1'b0;
      hi_r    <= {DATA_W{1'b0}};
      lo_r    <= {DATA_W{1'b0}};
    end else if (!stall_ex) begin
      whilo_r <= ex_whilo;
      hi_r    <= ex_hi;
      lo_r    <= ex_lo;
    end else if (!stall_mem) begin
      whilo_r <= 1'b0;
      hi_r    <= {DATA_W{1'b0}};
      lo_r    <= {DATA_W{1'b0}};
    end else begin
      whilo_r <= whilo_r;
      hi_r    <= hi_r;
      lo_r    <= lo_r;
    end
  end

  // Accumulate state: kept (re-loaded from execute) only while execute is
  // stalled; cleared once the operation leaves execute, and on flush/reset
  // so a pending accumulate is abandoned.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      temp_r <= {(2*DATA_W){1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else if (stall_ex) begin
      temp_r <= hilo_temp_i;
      cnt_r  <= cnt_i;
    end else begin
      temp_r <= {(2*DATA_W){1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end
  end

  assign mem_whilo   = whilo_r;
  assign mem_hi      = hi_r;
  assign mem_lo      = lo_r;
  assign hilo_temp_o = temp_r;
  assign cnt_o       = cnt_r;
`else
  // HI/LO and accumulate inputs are deliberately ignored in this build.
  logic unused_hilo_s;
  assign unused_hilo_s = ^{ex_whilo, ex_hi, ex_lo, hilo_temp_i, cnt_i};

  assign mem_whilo   = 1'b0;
  assign mem_hi      = {DATA_W{1'b0}};
  assign mem_lo      = {DATA_W{1'b0}};
  assign hilo_temp_o = {(2*DATA_W){1'b0}};
  assign cnt_o       = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ex_mem.sv
// ---------------------------------------------------------------------------
// tb_ex_mem -- self-checking bench for ex_mem. A table of sequential
// {inputs, expected outputs} records is applied one clock per record; the
// HI/LO and accumulate expectations are masked to zero when EX_MEM_HILO_EN
// is undefined. A hand-written full-hold sequence with changing inputs
// follows the table.
// ---------------------------------------------------------------------------
module tb_ex_mem;

`ifdef EX_MEM_HILO_EN
  localparam bit HILO_ON = 1'b1;
`else
  localparam bit HILO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall_ex, stall_mem, flush;
  logic [4:0]  ex_rw;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi, ex_lo;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_rw;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic        mem_valid;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int tests  = 0;
  int failed = 0;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush(flush), .ex_rw(ex_rw), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_rw(mem_rw), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_valid(mem_valid), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  // The stall controller must never stall memory while execute advances.
  always @(negedge clk) begin
    if (rst !== 1'b1)
      assert (!(stall_ex === 1'b0 && stall_mem === 1'b1))
        else $error("illegal stall combination stall_ex=0 stall_mem=1");
  end

  typedef struct {
    logic        rst, se, sm, fl;
    logic [4:0]  rw;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi, lo;
    logic [63:0] temp;
    logic [1:0]  cnt;
    logic [4:0]  e_rw;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_hi, e_lo;
    logic        e_valid;
    logic [63:0] e_temp;
    logic [1:0]  e_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stall_ex = v.se; stall_mem = v.sm; flush = v.fl;
    ex_rw = v.rw; ex_wreg = v.wreg; ex_wdata = v.wdata; ex_whilo = v.whilo;
    ex_hi = v.hi; ex_lo = v.lo; hilo_temp_i = v.temp; cnt_i = v.cnt;
  endtask

  task automatic check_bubble(input int idx);
    if (mem_valid === 1'b0) begin
      check("bubble_wreg", idx, {63'd0, mem_wreg}, 64'd0);
      check("bubble_whilo", idx, {63'd0, mem_whilo}, 64'd0);
    end
  endtask

  initial begin
    // rst se sm fl | rw wreg wdata whilo hi lo temp cnt | expected
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, 5'd7,1'b1,32'hAAAA_5555,1'b1,32'h11,32'h22,64'h3,2'd2,
                 5'd0,1'b0,32'h0,1'b0,32'h0,32'h0,1'b0,64'h0,2'd0};
    vecs[1]  = '{1'b1,1'b1,1'b1,1'b0, 5'd7,1'b1,32'hAAAA_5555,1'b1,32'h11,32'h22,64'h3,2'd2,
                 5'd0,1'b0,32'h0,1'b0,32'h0,32'h0,1'b0,64'h0,2'd0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0, 5'd3,1'b1,32'h0000_F0F0,1'b1,32'h1234,32'h5678,64'hCAFE,2'd3,
                 5'd3,1'b1,32'h0000_F0F0,1'b1,32'h1234,32'h5678,1'b1,64'h0,2'd0};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0, 5'd6,1'b1,32'h77,1'b1,32'h9,32'h9,64'h1_0000_0002,2'd1,
                 5'd0,1'b0,32'h0,1'b0,32'h0,32'h0,1'b0,64'h1_0000_0002,2'd1};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0, 5'd9,1'b1,32'h1111_2222,1'b0,32'h0,32'h0,64'h5,2'd2,
                 5'd9,1'b1,32'h1111_2222,1'b0,32'h0,32'h0,1'b1,64'h0,2'd0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0, 5'd4,1'b1,32'hDEAD_BEEF,1'b1,32'hAAAA,32'hBBBB,64'h0,2'd0,
                 5'd4,1'b1,32'hDEAD_BEEF,1'b1,32'hAAAA,32'hBBBB,1'b1,64'h0,2'd0};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b0, 5'd10,1'b0,32'h0,1'b0,32'h1,32'h2,64'h0123_4567_89AB_CDEF,2'd1,
                 5'd4,1'b1,32'hDEAD_BEEF,1'b1,32'hAAAA,32'hBBBB,1'b1,64'h0123_4567_89AB_CDEF,2'd1};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b0, 5'd11,1'b1,32'h1234_5678,1'b1,32'h3,32'h4,64'hFFFF_FFFF_0000_0000,2'd2,
                 5'd4,1'b1,32'hDEAD_BEEF,1'b1,32'hAAAA,32'hBBBB,1'b1,64'hFFFF_FFFF_0000_0000,2'd2};
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b0, 5'd0,1'b0,32'h5,1'b0,32'h5,32'h6,64'h8000_0000_0000_0001,2'd3,
                 5'd4,1'b1,32'hDEAD_BEEF,1'b1,32'hAAAA,32'hBBBB,1'b1,64'h8000_0000_0000_0001,2'd3};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b1, 5'd12,1'b1,32'h99,1'b1,32'h7,32'h8,64'h77,2'd1,
                 5'd0,1'b0,32'h0,1'b0,32'h0,32'h0,1'b0,64'h0,2'd0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0, 5'd31,1'b0,32'hFFFF_FFFF,1'b1,32'hFFFF_FFFF,32'h0,64'h1,2'd1,
                 5'd31,1'b0,32'hFFFF_FFFF,1'b1,32'hFFFF_FFFF,32'h0,1'b1,64'h0,2'd0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1, 5'd13,1'b1,32'h13,1'b1,32'h13,32'h13,64'h13,2'd3,
                 5'd0,1'b0,32'h0,1'b0,32'h0,32'h0,1'b0,64'h0,2'd0};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0, 5'd1,1'b1,32'h1,1'b0,32'h0,32'h8,64'h0,2'd0,
                 5'd1,1'b1,32'h1,1'b0,32'h0,32'h8,1'b1,64'h0,2'd0};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0, 5'd14,1'b1,32'h14,1'b1,32'h14,32'h14,64'hFFFF_FFFF_FFFF_FFFF,2'd2,
                 5'd0,1'b0,32'h0,1'b0,32'h0,32'h0,1'b0,64'hFFFF_FFFF_FFFF_FFFF,2'd2};
    vecs[14] = '{1'b1,1'b1,1'b1,1'b0, 5'd15,1'b1,32'h15,1'b1,32'h15,32'h15,64'h1,2'd3,
                 5'd0,1'b0,32'h0,1'b0,32'h0,32'h0,1'b0,64'h0,2'd0};
    vecs[15] = '{1'b0,1'b1,1'b1,1'b0, 5'd16,1'b1,32'h16,1'b1,32'h16,32'h16,64'h42,2'd1,
                 5'd0,1'b0,32'h0,1'b0,32'h0,32'h0,1'b0,64'h42,2'd1};
    vecs[16] = '{1'b0,1'b1,1'b1,1'b1, 5'd17,1'b1,32'h17,1'b1,32'h17,32'h17,64'h9,2'd3,
                 5'd0,1'b0,32'h0,1'b0,32'h0,32'h0,1'b0,64'h0,2'd0};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b0, 5'd2,1'b1,32'h2,1'b1,32'h5,32'h6,64'h0,2'd0,
                 5'd2,1'b1,32'h2,1'b1,32'h5,32'h6,1'b1,64'h0,2'd0};

    drive(vecs[0]);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check("mem_rw",    i, {59'd0, mem_rw},    {59'd0, vecs[i].e_rw});
      check("mem_wreg",  i, {63'd0, mem_wreg},  {63'd0, vecs[i].e_wreg});
      check("mem_wdata", i, {32'd0, mem_wdata}, {32'd0, vecs[i].e_wdata});
      check("mem_valid", i, {63'd0, mem_valid}, {63'd0, vecs[i].e_valid});
      check("mem_whilo", i, {63'd0, mem_whilo}, {63'd0, vecs[i].e_whilo & HILO_ON});
      check("mem_hi",    i, {32'd0, mem_hi},    {32'd0, vecs[i].e_hi & {32{HILO_ON}}});
      check("mem_lo",    i, {32'd0, mem_lo},    {32'd0, vecs[i].e_lo & {32{HILO_ON}}});
      check("hilo_temp", i, hilo_temp_o,        vecs[i].e_temp & {64{HILO_ON}});
      check("cnt",       i, {62'd0, cnt_o},     {62'd0, vecs[i].e_cnt & {2{HILO_ON}}});
      check_bubble(i);
    end

    // Full hold with changing inputs: payload must stay frozen.
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
    ex_rw = 5'd20; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF;
    ex_whilo = 1'b0; ex_hi = 32'h0; ex_lo = 32'h0;
    @(posedge clk);
    #1;
    check("hold_load", 100, {32'd0, mem_wdata}, 64'h0000_0000_DEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stall_ex = 1'b1; stall_mem = 1'b1;
      ex_rw = 5'($urandom_range(0, 31));
      ex_wreg = 1'b0;
      ex_wdata = $urandom() | 32'h0000_0001;
      @(posedge clk);
      #1;
      check("hold_wdata", 101 + k, {32'd0, mem_wdata}, 64'h0000_0000_DEAD_BEEF);
      check("hold_rw",    101 + k, {59'd0, mem_rw},    64'd20);
      check("hold_valid", 101 + k, {63'd0, mem_valid}, 64'd1);
      check("hold_wreg",  101 + k, {63'd0, mem_wreg},  64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
